// File: rtl/fractal_pkg.sv
// fractal_pkg: shared widths, iteration limit, kernel latency derivation and the slot sideband type.
// Contents: *_DEF width defaults, MAX_ITER, ITER_WIDTH, kernel_latency(), slot_t {valid, tag, cr, ci}.
package fractal_pkg;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int FRAC_WIDTH_DEF = 28;
   localparam int TAG_WIDTH_DEF  = 16;
   localparam int MUL_DEPTH_DEF  = 7;
   localparam int MAX_ITER       = 255;
   localparam int ITER_WIDTH     = $clog2(MAX_ITER + 1);

   // One register stage follows the multiplier pipeline inside the kernel.
   function automatic int kernel_latency(input int mul_depth);
      return mul_depth + 1;
   endfunction

   typedef struct packed {
      logic                      valid;
      logic [TAG_WIDTH_DEF-1:0]  tag;
      logic [DATA_WIDTH_DEF-1:0] cr;
      logic [DATA_WIDTH_DEF-1:0] ci;
   } slot_t;
endpackage

// File: rtl/fractal_slot_delay.sv
// fractal_slot_delay: DEPTH-stage shift register of slot_t that tracks the kernel pipeline.
// Ports: clk, resetn (async, active-low), i_slot (stage 0 input), o_slot (stage DEPTH-1 output).
// Only the valid bits are reset; payload flops are plain data registers.
module fractal_slot_delay
   import fractal_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic  clk,
   input  logic  resetn,
   input  slot_t i_slot,
   output slot_t o_slot
);
   logic [DEPTH-1:0] r_valid;
   slot_t            r_data [DEPTH];

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) r_valid <= '0;
      else         r_valid <= DEPTH'({r_valid, i_slot.valid});

   always_ff @(posedge clk) begin
      r_data[0] <= i_slot;
      for (int i = 1; i < DEPTH; i++) r_data[i] <= r_data[i-1];
   end

   always_comb begin
      o_slot       = r_data[DEPTH-1];
      o_slot.valid = r_valid[DEPTH-1];
   end
endmodule

// File: rtl/fractal_scheduler.sv
// fractal_scheduler: slot scheduler for the pipelined z' = z^2 + c kernel (inject / recirculate / retire).
// Ports: clk, resetn (async, active-low); enable; in_valid/in_ready/in_cr/in_ci/in_tag (pixel input);
//        out_valid/out_ready/out_iter/out_tag (registered result stream); busy;
//        k_* (kernel inputs driven, kernel outputs returned KERNEL_LATENCY cycles later).
// Build option: define JULIA_EN to add julia_mode/julia_cr/julia_ci (Julia injection z=in_c, c=julia_c).
module fractal_scheduler
   import fractal_pkg::*;
#(
   parameter int DATA_WIDTH         = DATA_WIDTH_DEF,
   parameter int FRAC_WIDTH         = FRAC_WIDTH_DEF,
   parameter int MUL_PIPELINE_DEPTH = MUL_DEPTH_DEF,
   parameter int TAG_WIDTH          = TAG_WIDTH_DEF
)(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  enable,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_cr,
   input  logic [DATA_WIDTH-1:0] in_ci,
   input  logic [TAG_WIDTH-1:0]  in_tag,
`ifdef JULIA_EN
   input  logic                  julia_mode,
   input  logic [DATA_WIDTH-1:0] julia_cr,
   input  logic [DATA_WIDTH-1:0] julia_ci,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ITER_WIDTH-1:0] out_iter,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic                  busy,
   output logic                  k_inc_enabled,
   output logic [DATA_WIDTH-1:0] k_zr_in,
   output logic [DATA_WIDTH-1:0] k_zi_in,
   output logic [DATA_WIDTH-1:0] k_cr_in,
   output logic [DATA_WIDTH-1:0] k_ci_in,
   output logic [ITER_WIDTH-1:0] k_iter_in,
   output logic                  k_finished_in,
   input  logic [DATA_WIDTH-1:0] k_zr_out,
   input  logic [DATA_WIDTH-1:0] k_zi_out,
   input  logic [ITER_WIDTH-1:0] k_iter_out,
   input  logic                  k_finished_out
);
   localparam int KERNEL_LATENCY = kernel_latency(MUL_PIPELINE_DEPTH);
   localparam int CW             = $clog2(KERNEL_LATENCY + 1);

   // slot_t is sized from the package, so the data/tag widths are fixed to it.
   if (DATA_WIDTH != DATA_WIDTH_DEF || TAG_WIDTH != TAG_WIDTH_DEF || FRAC_WIDTH >= DATA_WIDTH)
      $error("fractal_scheduler: DATA_WIDTH/TAG_WIDTH must match fractal_pkg::slot_t");

   slot_t                 w_ret;
   slot_t                 w_slot_in;
   logic                  w_out_cap;
   logic                  w_retire;
   logic                  w_keep;
   logic                  w_inject;
   logic [DATA_WIDTH-1:0] w_inj_zr;
   logic [DATA_WIDTH-1:0] w_inj_zi;
   logic [DATA_WIDTH-1:0] w_inj_cr;
   logic [DATA_WIDTH-1:0] w_inj_ci;
   logic                  r_out_valid;
   logic [ITER_WIDTH-1:0] r_out_iter;
   logic [TAG_WIDTH-1:0]  r_out_tag;
   logic [CW-1:0]         r_count;

   // A returning slot stays occupied unless it finished and the output register can take it;
   // a finished item that cannot retire is sent round again with finished=1 (iter held by kernel).
   assign w_out_cap = !r_out_valid || out_ready;
   assign w_retire  = w_ret.valid && k_finished_out && w_out_cap;
   assign w_keep    = w_ret.valid && !w_retire;
   assign in_ready  = enable && !w_keep;
   assign w_inject  = in_ready && in_valid;

`ifdef JULIA_EN
   assign w_inj_zr = julia_mode ? in_cr : '0;
   assign w_inj_zi = julia_mode ? in_ci : '0;
   assign w_inj_cr = julia_mode ? julia_cr : in_cr;
   assign w_inj_ci = julia_mode ? julia_ci : in_ci;
`else
   assign w_inj_zr = '0;
   assign w_inj_zi = '0;
   assign w_inj_cr = in_cr;
   assign w_inj_ci = in_ci;
`endif

   always_comb begin
      k_zr_in         = w_keep ? k_zr_out : w_inj_zr;
      k_zi_in         = w_keep ? k_zi_out : w_inj_zi;
      k_cr_in         = w_keep ? w_ret.cr : w_inj_cr;
      k_ci_in         = w_keep ? w_ret.ci : w_inj_ci;
      k_iter_in       = w_keep ? k_iter_out : '0;
      k_finished_in   = w_keep && k_finished_out;
      k_inc_enabled   = w_keep || w_inject;
      w_slot_in.valid = k_inc_enabled;
      w_slot_in.tag   = w_keep ? w_ret.tag : in_tag;
      w_slot_in.cr    = k_cr_in;
      w_slot_in.ci    = k_ci_in;
   end

   fractal_slot_delay #(.DEPTH(KERNEL_LATENCY)) u_ring (
      .clk    (clk),
      .resetn (resetn),
      .i_slot (w_slot_in),
      .o_slot (w_ret)
   );

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         r_out_valid <= 1'b0;
         r_out_iter  <= '0;
         r_out_tag   <= '0;
         r_count     <= '0;
      end else begin
         if (w_retire) begin
            r_out_iter <= k_iter_out;
            r_out_tag  <= w_ret.tag;
         end
         r_out_valid <= w_retire || (r_out_valid && !out_ready);
         r_count     <= r_count + CW'(w_inject) - CW'(w_retire);
      end

   assign out_valid = r_out_valid;
   assign out_iter  = r_out_iter;
   assign out_tag   = r_out_tag;
   assign busy      = (r_count != '0) || r_out_valid;
endmodule

// File: tb/tb_fractal_scheduler.sv
// tb_fractal_scheduler: kernel model + transaction scoreboard bench for fractal_scheduler.
module tb_fractal_scheduler;
   import fractal_pkg::*;
   localparam int KL = kernel_latency(MUL_DEPTH_DEF);
   localparam logic [31:0] ONE = 32'h1000_0000;

   logic        clk = 0, resetn = 0, enable = 0, in_valid = 0, out_ready = 0;
   logic [31:0] in_cr = 0, in_ci = 0;
   logic [15:0] in_tag = 0;
   logic        in_ready, out_valid, busy, k_inc_enabled, k_finished_in, k_finished_out;
   logic [7:0]  out_iter, k_iter_in, k_iter_out;
   logic [15:0] out_tag;
   logic [31:0] k_zr_in, k_zi_in, k_cr_in, k_ci_in, k_zr_out, k_zi_out;
`ifdef JULIA_EN
   logic        julia_mode = 0;
   logic [31:0] julia_cr = 0, julia_ci = 0;
`endif

   fractal_scheduler dut (
      .clk(clk), .resetn(resetn), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
      .in_cr(in_cr), .in_ci(in_ci), .in_tag(in_tag),
`ifdef JULIA_EN
      .julia_mode(julia_mode), .julia_cr(julia_cr), .julia_ci(julia_ci),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_iter(out_iter), .out_tag(out_tag), .busy(busy),
      .k_inc_enabled(k_inc_enabled), .k_zr_in(k_zr_in), .k_zi_in(k_zi_in), .k_cr_in(k_cr_in),
      .k_ci_in(k_ci_in), .k_iter_in(k_iter_in), .k_finished_in(k_finished_in),
      .k_zr_out(k_zr_out), .k_zi_out(k_zi_out), .k_iter_out(k_iter_out), .k_finished_out(k_finished_out)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc_n = 0, outstanding = 0, acc_cyc = 0;
   int exp_iter [int];
   int em_tag [$], em_iter [$], em_cyc [$];
   logic        prev_hold = 0;
   logic [7:0]  prev_iter = 0;
   logic [15:0] prev_tag = 0;

   function automatic void chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
      end
   endfunction

   function automatic logic [63:0] zstep(input logic [31:0] zr, zi, cr, ci);
      longint a, b, r, i;
      a = longint'($signed(zr));
      b = longint'($signed(zi));
      r = ((a * a - b * b) >>> 28) + longint'($signed(cr));
      i = ((a * b) >>> 27) + longint'($signed(ci));
      return {r[31:0], i[31:0]};
   endfunction

   function automatic bit escaped(input logic [31:0] zr, zi);
      longint a, b;
      logic [64:0] m;
      a = longint'($signed(zr));
      b = longint'($signed(zi));
      m = 65'(a * a) + 65'(b * b);
      return m > (65'd4 << 56);
   endfunction

   function automatic int ref_iter(input logic [31:0] zr0, zi0, cr, ci);
      logic [31:0] zr, zi;
      logic [63:0] n;
      zr = zr0;
      zi = zi0;
      for (int it = 1; it <= MAX_ITER; it++) begin
         if (escaped(zr, zi) || it == MAX_ITER) return it;
         n = zstep(zr, zi, cr, ci);
         zr = n[63:32];
         zi = n[31:0];
      end
      return MAX_ITER;
   endfunction

   // Kernel model: one pass per item, result visible KL cycles after it is driven.
   logic [31:0] kzr [KL], kzi [KL];
   logic [7:0]  kit [KL];
   logic        kfin [KL];
   assign k_zr_out = kzr[KL-1];
   assign k_zi_out = kzi[KL-1];
   assign k_iter_out = kit[KL-1];
   assign k_finished_out = kfin[KL-1];
   initial for (int i = 0; i < KL; i++) begin kzr[i] = 0; kzi[i] = 0; kit[i] = 0; kfin[i] = 0; end

   always @(posedge clk) begin
      logic [63:0] nz;
      nz = zstep(k_zr_in, k_zi_in, k_cr_in, k_ci_in);
      for (int i = KL - 1; i > 0; i--) begin
         kzr[i] <= kzr[i-1]; kzi[i] <= kzi[i-1]; kit[i] <= kit[i-1]; kfin[i] <= kfin[i-1];
      end
      kzr[0]  <= k_finished_in ? k_zr_in : nz[63:32];
      kzi[0]  <= k_finished_in ? k_zi_in : nz[31:0];
      kit[0]  <= (k_finished_in || !k_inc_enabled) ? k_iter_in : k_iter_in + 8'd1;
      kfin[0] <= k_finished_in || (k_inc_enabled && (escaped(k_zr_in, k_zi_in) || k_iter_in + 8'd1 == 8'(MAX_ITER)));
   end

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Compare process: transaction scoreboard plus per-cycle protocol rules.
   always @(negedge clk) begin
      if (!resetn) begin
         exp_iter.delete();
         outstanding = 0;
         prev_hold = 0;
      end else begin
         logic [31:0] zr0, zi0, cr, ci;
         chk("busy", busy, outstanding != 0);
         chk("occupancy_bound", outstanding <= KL + 1, 1);
         if (!enable) chk("in_ready_gated", in_ready, 0);
         if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_tag", out_tag, prev_tag);
            chk("hold_iter", out_iter, prev_iter);
         end
         if (in_valid && in_ready) begin
            zr0 = 0; zi0 = 0; cr = in_cr; ci = in_ci;
`ifdef JULIA_EN
            if (julia_mode) begin zr0 = in_cr; zi0 = in_ci; cr = julia_cr; ci = julia_ci; end
`endif
            exp_iter[int'(in_tag)] = ref_iter(zr0, zi0, cr, ci);
            outstanding++;
            acc_cyc = cyc_n;
         end
         if (out_valid && out_ready) begin
            chk("emit_tag_known", exp_iter.exists(int'(out_tag)), 1);
            if (exp_iter.exists(int'(out_tag))) begin
               chk("emit_iter", out_iter, exp_iter[int'(out_tag)]);
               exp_iter.delete(int'(out_tag));
            end
            em_tag.push_back(int'(out_tag));
            em_iter.push_back(int'(out_iter));
            em_cyc.push_back(cyc_n);
            outstanding--;
         end
         prev_hold = out_valid && !out_ready;
         prev_tag = out_tag;
         prev_iter = out_iter;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] cr, ci, input logic [15:0] tag);
      int n = 0;
      in_valid = 1; in_cr = cr; in_ci = ci; in_tag = tag;
      #1;
      while (!in_ready && n < 3000) begin cyc(); #1; n++; end
      chk("offer_accepted", in_ready, 1);
      cyc();
      in_valid = 0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((busy || exp_iter.num() != 0) && n < 8000) begin cyc(); n++; end
      chk({name, "_busy_low"}, busy, 0);
      chk({name, "_scoreboard_empty"}, exp_iter.num(), 0);
   endtask

   initial begin
      int n0, seen;
      logic [15:0] tag;
      bit rdy [17];
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_out_iter", out_iter, 0);
      chk("reset_out_tag", out_tag, 0);
      cyc(); cyc();
      resetn = 1; enable = 1; out_ready = 1;
      #1;
      chk("first_cycle_in_ready", in_ready, 1);

      // Single escaping pixel: two passes, fixed latency.
      n0 = em_tag.size();
      offer(3 * ONE, 0, 16'd5);
      drain("c3");
      chk("c3_count", em_tag.size() - n0, 1);
      if (em_tag.size() > n0) begin
         chk("c3_iter", em_iter[n0], 2);
         chk("c3_tag", em_tag[n0], 5);
         chk("c3_latency", em_cyc[n0] - acc_cyc, 2 * KL + 1);
      end

      // |z|^2 == 4.0 does not escape; c=0 runs to the iteration cap.
      n0 = em_tag.size();
      offer(2 * ONE, 0, 16'd6);
      offer(0, 0, 16'd7);
      drain("c2_c0");
      chk("c2_c0_count", em_tag.size() - n0, 2);
      if (em_tag.size() >= n0 + 2) begin
         chk("c2_iter", em_iter[n0], 3);
         chk("c0_iter", em_iter[n0+1], 255);
      end

      // Ten back-to-back pixels: eight slots fill, then a stall until the first one retires.
      n0 = em_tag.size();
      tag = 16'd100;
      seen = 0;
      in_valid = 1;
      for (int c = 0; c < 200 && seen < 10; c++) begin
         in_cr = 3 * ONE; in_ci = 0; in_tag = tag;
         #1;
         if (c < 17) rdy[c] = in_ready;
         if (in_ready) begin tag++; seen++; end
         cyc();
      end
      in_valid = 0;
      for (int c = 0; c < 17; c++) chk($sformatf("b2b_in_ready_%0d", c), rdy[c], c < 8 || c == 16);
      drain("b2b");
      chk("b2b_count", em_tag.size() - n0, 10);

      // Output stall: first result held, second recirculates with iter frozen.
      n0 = em_tag.size();
      out_ready = 0;
      offer(3 * ONE, 0, 16'd200);
      offer(3 * ONE, ONE, 16'd201);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (k_finished_in) begin chk("frozen_iter", k_iter_in, 2); seen++; end
         cyc();
      end
      chk("frozen_seen", seen > 0, 1);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_tag", out_tag, 200);
      chk("stall_out_iter", out_iter, 2);
      chk("stall_busy", busy, 1);
      out_ready = 1;
      drain("stall");
      chk("stall_count", em_tag.size() - n0, 2);
      if (em_tag.size() >= n0 + 2) begin
         chk("stall_first_tag", em_tag[n0], 200);
         chk("stall_second_tag", em_tag[n0+1], 201);
         chk("stall_second_iter", em_iter[n0+1], 2);
      end

      // Asynchronous reset with eight long-running pixels in flight.
      for (int i = 0; i < 8; i++) offer(0, 0, 16'(300 + i));
      cyc(); cyc();
      resetn = 0;
      #1;
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_busy", busy, 0);
      cyc(); cyc();
      resetn = 1;
      n0 = em_tag.size();
      offer(3 * ONE, 0, 16'd400);
      drain("post_reset");
      chk("post_reset_count", em_tag.size() - n0, 1);
      if (em_tag.size() > n0) chk("post_reset_iter", em_iter[n0], 2);

      // enable low: no injections, in-flight items still drain.
      n0 = em_tag.size();
      offer(3 * ONE, 0, 16'd500);
      offer(2 * ONE, 0, 16'd501);
      enable = 0; in_valid = 1; in_cr = 3 * ONE; in_tag = 16'd502;
      for (int c = 0; c < 60; c++) begin
         if (c == 5 || c == 40) chk($sformatf("disabled_in_ready_%0d", c), in_ready, 0);
         cyc();
      end
      in_valid = 0;
      drain("disabled");
      chk("disabled_count", em_tag.size() - n0, 2);
      enable = 1;

`ifdef JULIA_EN
      n0 = em_tag.size();
      julia_mode = 1; julia_cr = 0; julia_ci = 0;
      offer(3 * ONE, 0, 16'd600);
      drain("julia");
      if (em_tag.size() > n0) chk("julia_iter", em_iter[n0], 1);
      else chk("julia_count", em_tag.size() - n0, 1);
      julia_mode = 0;
`endif

      // Randomized traffic against the scoreboard.
      tag = 16'd1000;
      for (int c = 0; c < 1500; c++) begin
         in_valid = $urandom_range(0, 9) < 7;
         out_ready = $urandom_range(0, 9) < 6;
         enable = $urandom_range(0, 9) != 0;
         in_cr = 32'($urandom_range(0, 1342177280)) - 32'd671088640;
         in_ci = 32'($urandom_range(0, 1342177280)) - 32'd671088640;
         in_tag = tag++;
`ifdef JULIA_EN
         julia_mode = $urandom_range(0, 1) == 1;
         julia_cr = 32'($urandom_range(0, 536870912)) - 32'd268435456;
         julia_ci = 32'($urandom_range(0, 536870912)) - 32'd268435456;
`endif
         cyc();
      end
      in_valid = 0; out_ready = 1; enable = 1;
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
